// File: rtl/cntr_bs_queues.sv
// -----------------------------------------------------------------------------
// cntr_bs_queues
//   A bank of FN = RD_FIFO_NUM + WR_FIFO_NUM circular-buffer request queues.
//   Queues 0..RD_FIFO_NUM-1 are read queues of depth RD_FIFO_SIZE. The
//   remaining queues are write queues of depth WR_FIFO_SIZE. At most one
//   push and one pop are accepted per cycle. A dequeued entry is presented
//   on registered outputs one cycle after the pop.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   push / pop   [FN]    one-hot enqueue / dequeue request per queue
//   dq_i idx_i ra_i ca_i entry fields (dq_i is kept by write queues only)
//   grant                push accepted this cycle (combinational)
//   full mid valid_o     per-queue status flags, from registered occupancy
//   occ      [FN*OW]     per-queue occupancy, queue i at [i*OW +: OW]
//   last_ra  [FN*RA]     row address of the last accepted push per queue
//   out_valid, dq_o, idx_o, ra_o, ca_o, type_o   registered dequeue result
//   err      [3]         sticky: [0] push to full, [1] pop of empty,
//                        [2] multi-hot push or pop vector
// -----------------------------------------------------------------------------
module cntr_bs_queues #(
    parameter int RD_FIFO_NUM  = 4,
    parameter int WR_FIFO_NUM  = 3,
    parameter int RD_FIFO_SIZE = 4,
    parameter int WR_FIFO_SIZE = 3,
    parameter int DQ           = 16,
    parameter int IDX          = 7,
    parameter int RA           = 16,
    parameter int CA           = 10,
    localparam int FN          = RD_FIFO_NUM + WR_FIFO_NUM,
    localparam int MAXD        = (RD_FIFO_SIZE > WR_FIFO_SIZE) ? RD_FIFO_SIZE : WR_FIFO_SIZE,
    localparam int OW          = $clog2(MAXD + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [FN-1:0]    push,
    input  logic [FN-1:0]    pop,
    input  logic [DQ-1:0]    dq_i,
    input  logic [IDX-1:0]   idx_i,
    input  logic [RA-1:0]    ra_i,
    input  logic [CA-1:0]    ca_i,
    output logic             grant,
    output logic [FN-1:0]    full,
    output logic [FN-1:0]    mid,
    output logic [FN-1:0]    valid_o,
    output logic [FN*OW-1:0] occ,
    output logic [FN*RA-1:0] last_ra,
    output logic             out_valid,
    output logic [DQ-1:0]    dq_o,
    output logic [IDX-1:0]   idx_o,
    output logic [RA-1:0]    ra_o,
    output logic [CA-1:0]    ca_o,
    output logic             type_o,
    output logic [2:0]       err
);

    localparam int PW = $clog2(MAXD);
    localparam int IW = (FN > 1) ? $clog2(FN) : 1;

    typedef struct packed {
        logic [DQ-1:0]  dq;
        logic [IDX-1:0] idx;
        logic [RA-1:0]  ra;
        logic [CA-1:0]  ca;
    } entry_t;

    entry_t         mem_q     [FN][MAXD];
    logic [PW-1:0]  wr_ptr_q  [FN];
    logic [PW-1:0]  wr_ptr_d  [FN];
    logic [PW-1:0]  rd_ptr_q  [FN];
    logic [PW-1:0]  rd_ptr_d  [FN];
    logic [OW-1:0]  occ_q     [FN];
    logic [OW-1:0]  occ_d     [FN];
    logic [RA-1:0]  last_ra_q [FN];
    logic [RA-1:0]  last_ra_d [FN];

    entry_t         out_q;
    logic           out_valid_q;
    logic           type_q;
    logic [2:0]     err_q;

    function automatic int depth_of(input int q);
        return (q < RD_FIFO_NUM) ? RD_FIFO_SIZE : WR_FIFO_SIZE;
    endfunction

    // Explicit wrap compare so non-power-of-2 depths cycle through 0..depth-1.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p, input int q);
        return (p == PW'(depth_of(q) - 1)) ? '0 : p + PW'(1);
    endfunction

    // Status flags come from registered occupancy only.
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        full    = '0;
        mid     = '0;
        valid_o = '0;
        occ     = '0;
        last_ra = '0;
        for (int i = 0; i < FN; i++) begin
            full[i]              = (occ_q[i] == OW'(depth_of(i)));
            mid[i]               = ({occ_q[i], 1'b0} >= (OW+1)'(depth_of(i)));
            valid_o[i]           = (occ_q[i] != '0);
            occ[i*OW +: OW]      = occ_q[i];
            last_ra[i*RA +: RA]  = last_ra_q[i];
        end
    end

    // Request decode: a vector is usable only when exactly one bit is set.
    logic          push_oh, pop_oh, push_multi, pop_multi, push_ok, pop_ok;
    logic [IW-1:0] push_idx, pop_idx;
    logic [FN-1:0] push_hit, pop_hit;

    assign push_oh    = (push != '0) && ((push & (push - FN'(1))) == '0);
    assign pop_oh     = (pop  != '0) && ((pop  & (pop  - FN'(1))) == '0);
    assign push_multi = (push != '0) && !push_oh;
    assign pop_multi  = (pop  != '0) && !pop_oh;

    always_comb begin
        push_idx = '0;
        pop_idx  = '0;
        for (int i = 0; i < FN; i++) begin
            if (push[i]) push_idx = IW'(i);
            if (pop[i])  pop_idx  = IW'(i);
        end
    end

    // A same-cycle pop never makes room for a push into a full queue.
    assign push_ok  = push_oh && !full[push_idx];
    assign pop_ok   = pop_oh && valid_o[pop_idx];
    assign push_hit = push_ok ? push : '0;
    assign pop_hit  = pop_ok  ? pop  : '0;
    assign grant    = push_ok;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        last_ra_d = last_ra_q;
        for (int i = 0; i < FN; i++) begin
            if (push_hit[i]) begin
                wr_ptr_d[i]  = next_ptr(wr_ptr_q[i], i);
                last_ra_d[i] = ra_i;
            end
            if (pop_hit[i]) begin
                rd_ptr_d[i] = next_ptr(rd_ptr_q[i], i);
            end
            case ({push_hit[i], pop_hit[i]})
                2'b10:   occ_d[i] = occ_q[i] + OW'(1);
                2'b01:   occ_d[i] = occ_q[i] - OW'(1);
                default: occ_d[i] = occ_q[i];
            endcase
        end
    end

    entry_t head;
    assign head = mem_q[pop_idx][rd_ptr_q[pop_idx]];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FN; i++) begin
                wr_ptr_q[i]  <= '0;
                rd_ptr_q[i]  <= '0;
                occ_q[i]     <= '0;
                last_ra_q[i] <= '0;
            end
            out_q       <= '0;
            out_valid_q <= 1'b0;
            type_q      <= 1'b0;
            err_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            last_ra_q   <= last_ra_d;
            out_valid_q <= pop_ok;
            if (pop_ok) begin
                out_q  <= head;
                type_q <= (pop_idx < IW'(RD_FIFO_NUM));
            end
            err_q <= err_q | {push_multi || pop_multi,
                              pop_oh && !valid_o[pop_idx],
                              push_oh && full[push_idx]};
        end
    end

    // NOTE: the entry storage has no reset; occupancy and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[push_idx][wr_ptr_q[push_idx]] <= '{
                dq:  (push_idx < IW'(RD_FIFO_NUM)) ? '0 : dq_i,
                idx: idx_i,
                ra:  ra_i,
                ca:  ca_i
            };
        end
    end

    assign out_valid = out_valid_q;
    assign dq_o      = out_q.dq;
    assign idx_o     = out_q.idx;
    assign ra_o      = out_q.ra;
    assign ca_o      = out_q.ca;
    assign type_o    = type_q;
    assign err       = err_q;

endmodule

// File: tb/tb_cntr_bs_queues.sv
// -----------------------------------------------------------------------------
// tb_cntr_bs_queues
//   Directed stimulus for cntr_bs_queues with default parameters. A queue-based
//   reference model is checked against every DUT output on each falling edge;
//   literal expectations at fixed points pin the model itself.
// -----------------------------------------------------------------------------
module tb_cntr_bs_queues;

    localparam int FN = 7;
    localparam int RD = 4;
    localparam int OW = 3;
    localparam int RA = 16;

    localparam logic [FN-1:0] Q0 = 7'b0000001;
    localparam logic [FN-1:0] Q1 = 7'b0000010;
    localparam logic [FN-1:0] Q4 = 7'b0010000;
    localparam logic [FN-1:0] Q5 = 7'b0100000;
    localparam logic [FN-1:0] Q6 = 7'b1000000;

    logic             clk, rst_n;
    logic [FN-1:0]    push, pop;
    logic [15:0]      dq_i;
    logic [6:0]       idx_i;
    logic [15:0]      ra_i;
    logic [9:0]       ca_i;
    logic             grant;
    logic [FN-1:0]    full, mid, valid_o;
    logic [FN*OW-1:0] occ;
    logic [FN*RA-1:0] last_ra;
    logic             out_valid;
    logic [15:0]      dq_o;
    logic [6:0]       idx_o;
    logic [15:0]      ra_o;
    logic [9:0]       ca_o;
    logic             type_o;
    logic [2:0]       err;

    cntr_bs_queues #(
        .RD_FIFO_NUM(4), .WR_FIFO_NUM(3), .RD_FIFO_SIZE(4), .WR_FIFO_SIZE(3),
        .DQ(16), .IDX(7), .RA(16), .CA(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
        .dq_i(dq_i), .idx_i(idx_i), .ra_i(ra_i), .ca_i(ca_i),
        .grant(grant), .full(full), .mid(mid), .valid_o(valid_o),
        .occ(occ), .last_ra(last_ra), .out_valid(out_valid),
        .dq_o(dq_o), .idx_o(idx_o), .ra_o(ra_o), .ca_o(ca_o),
        .type_o(type_o), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [15:0] dq;
        logic [6:0]  idx;
        logic [15:0] ra;
        logic [9:0]  ca;
    } ent_t;

    ent_t        mq [FN][$];
    logic [15:0] m_last_ra [FN];
    ent_t        m_out;
    logic        m_ov, m_type;
    logic [2:0]  m_err;

    function automatic int depth(input int q);
        return (q < RD) ? 4 : 3;
    endfunction

    int   pi, po;
    logic p_oh, q_oh, g_exp, pop_exp;
    ent_t e;

    initial begin
        m_out = '0; m_ov = 0; m_type = 0; m_err = '0;
        for (int i = 0; i < FN; i++) m_last_ra[i] = '0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FN; i++) begin
                mq[i].delete();
                m_last_ra[i] = '0;
            end
            m_out = '0; m_ov = 0; m_type = 0; m_err = '0;
        end

        pi = 0; po = 0;
        for (int i = 0; i < FN; i++) begin
            if (push[i]) pi = i;
            if (pop[i])  po = i;
        end
        p_oh    = $onehot(push);
        q_oh    = $onehot(pop);
        g_exp   = p_oh && (mq[pi].size() < depth(pi));
        pop_exp = q_oh && (mq[po].size() != 0);

        check("m_grant", grant, g_exp);
        check("m_out_valid", out_valid, m_ov);
        check("m_dq_o", dq_o, m_out.dq);
        check("m_idx_o", idx_o, m_out.idx);
        check("m_ra_o", ra_o, m_out.ra);
        check("m_ca_o", ca_o, m_out.ca);
        check("m_type_o", type_o, m_type);
        check("m_err", err, m_err);
        for (int i = 0; i < FN; i++) begin
            check($sformatf("m_occ%0d", i), occ[i*OW +: OW], mq[i].size());
            check($sformatf("m_full%0d", i), full[i], mq[i].size() == depth(i));
            check($sformatf("m_mid%0d", i), mid[i], 2 * mq[i].size() >= depth(i));
            check($sformatf("m_valid%0d", i), valid_o[i], mq[i].size() != 0);
            check($sformatf("m_last_ra%0d", i), last_ra[i*RA +: RA], m_last_ra[i]);
        end

        if (rst_n) begin
            m_err = m_err | {($countones(push) > 1) || ($countones(pop) > 1),
                             q_oh && (mq[po].size() == 0),
                             p_oh && !g_exp};
            m_ov = pop_exp;
            if (pop_exp) begin
                m_out  = mq[po].pop_front();
                m_type = (po < RD);
            end
            if (g_exp) begin
                e.dq  = (pi < RD) ? 16'h0 : dq_i;
                e.idx = idx_i;
                e.ra  = ra_i;
                e.ca  = ca_i;
                mq[pi].push_back(e);
                m_last_ra[pi] = ra_i;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [FN-1:0] p, input logic [FN-1:0] q,
                         input logic [15:0] d, input logic [15:0] r);
        push  = p;
        pop   = q;
        dq_i  = d;
        idx_i = d[6:0] ^ 7'h2A;
        ra_i  = r;
        ca_i  = r[9:0] ^ 10'h155;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] drain_exp [3];

    initial begin
        drain_exp = '{16'h1111, 16'h2222, 16'h3333};
        rst_n = 1'b0;
        drive('0, '0, '0, '0);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_occ", occ, 0);
        check("rst_err", err, 0);
        #11 rst_n = 1'b1;
        tick;
        tick;
        tick;

        // single push/pop on read queue 0
        drive(Q0, '0, 16'hBEEF, 16'h1234);
        #1 check("q0_push_grant", grant, 1);
        tick;
        check("q0_occ", occ[2:0], 1);
        check("q0_valid", valid_o[0], 1);
        check("q0_last_ra", last_ra[15:0], 16'h1234);
        drive('0, Q0, '0, '0);
        tick;
        check("q0_pop_out_valid", out_valid, 1);
        check("q0_pop_ra", ra_o, 16'h1234);
        check("q0_pop_type", type_o, 1);
        check("q0_pop_dq_zero", dq_o, 0);
        drive('0, '0, '0, '0);
        tick;
        check("idle_out_valid", out_valid, 0);
        check("idle_ra_hold", ra_o, 16'h1234);

        // fill write queue 4 and overflow it
        drive(Q4, '0, 16'h1111, 16'h4001);
        tick;
        check("q4_mid_after1", mid[4], 0);
        drive(Q4, '0, 16'h2222, 16'h4002);
        tick;
        check("q4_mid_after2", mid[4], 1);
        check("q4_full_after2", full[4], 0);
        drive(Q4, '0, 16'h3333, 16'h4003);
        tick;
        check("q4_full_after3", full[4], 1);
        check("no_err_yet", err, 0);
        drive(Q4, '0, 16'h4444, 16'h4004);
        #1 check("q4_overflow_grant", grant, 0);
        tick;
        check("q4_overflow_err0", err[0], 1);
        check("q4_occ_stays", occ[14:12], 3);
        check("q4_last_ra_kept", last_ra[4*RA +: RA], 16'h4003);

        // multi-hot push, pop of empty
        drive(7'b0000011, '0, 16'h5555, 16'h5005);
        #1 check("multi_grant", grant, 0);
        tick;
        check("multi_err2", err[2], 1);
        check("multi_occ0", occ[2:0], 0);
        check("multi_occ1", occ[5:3], 0);
        drive('0, 7'b0000100, '0, '0);
        tick;
        check("empty_pop_out_valid", out_valid, 0);
        check("empty_pop_err", err, 3'b111);

        // simultaneous push/pop on write queue 5
        drive(Q5, '0, 16'hAAAA, 16'h5A5A);
        tick;
        drive(Q5, Q5, 16'hBBBB, 16'h5B5B);
        tick;
        check("q5_occ_same", occ[17:15], 1);
        check("q5_dq_a", dq_o, 16'hAAAA);
        check("q5_type", type_o, 0);
        drive('0, Q5, '0, '0);
        tick;
        check("q5_dq_b", dq_o, 16'hBBBB);
        check("q5_occ_empty", occ[17:15], 0);

        // drain queue 4 in push order
        for (int k = 0; k < 3; k++) begin
            drive('0, Q4, '0, '0);
            tick;
            check($sformatf("q4_drain%0d", k), dq_o, drain_exp[k]);
        end

        // five push/pop rounds on queue 6 (pointer wrap at depth 3)
        for (int k = 0; k < 5; k++) begin
            drive(Q6, '0, 16'h6000 + 16'(k), 16'h0600 + 16'(k));
            tick;
            drive('0, Q6, '0, '0);
            tick;
            check($sformatf("q6_round%0d_dq", k), dq_o, 16'h6000 + 16'(k));
            check($sformatf("q6_round%0d_ra", k), ra_o, 16'h0600 + 16'(k));
        end

        // queue 6 kept at two entries while pushing and popping together
        drive(Q6, '0, 16'hC000, 16'h0C00);
        tick;
        drive(Q6, '0, 16'hC001, 16'h0C01);
        tick;
        for (int k = 0; k < 5; k++) begin
            drive(Q6, Q6, 16'hC002 + 16'(k), 16'h0C02 + 16'(k));
            tick;
            check($sformatf("q6_stream%0d", k), dq_o, 16'hC000 + 16'(k));
        end
        drive('0, Q6, '0, '0);
        tick;
        tick;

        // read queue 1 wrap with overlapping push/pop
        drive(Q1, '0, 16'h0001, 16'h1001);
        tick;
        for (int k = 0; k < 6; k++) begin
            drive(Q1, Q1, 16'h0002 + 16'(k), 16'h1002 + 16'(k));
            tick;
            check($sformatf("q1_stream%0d_ra", k), ra_o, 16'h1001 + 16'(k));
        end
        drive('0, Q1, '0, '0);
        tick;

        // reset in the middle of traffic
        drive(Q0, '0, 16'h0001, 16'h7777);
        tick;
        drive(Q6, '0, 16'h9999, 16'h0999);
        tick;
        drive(Q6, Q6, 16'h8888, 16'h0888);
        tick;
        check("pre_rst_out_valid", out_valid, 1);
        check("pre_rst_dq", dq_o, 16'h9999);
        drive('0, '0, '0, '0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_dq", dq_o, 0);
        check("async_rst_ra", ra_o, 0);
        check("async_rst_occ", occ, 0);
        check("async_rst_valid", valid_o, 0);
        check("async_rst_last_ra", last_ra, 0);
        check("async_rst_err", err, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick;
        drive(Q6, '0, 16'hABCD, 16'h0ABC);
        tick;
        check("post_rst_occ6", occ[18 +: 3], 1);
        drive('0, Q6, '0, '0);
        tick;
        check("post_rst_dq", dq_o, 16'hABCD);
        drive('0, '0, '0, '0);
        tick;
        tick;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cntr_bs_queues.md
CNTR_BS_QUEUES -- requirements
Module: cntr_bs_queues

Interface
REQ-001 SHALL have parameter RD_FIFO_NUM, default 4: number of read queues, indices 0..RD_FIFO_NUM-1.
REQ-002 SHALL have parameter WR_FIFO_NUM, default 3: number of write queues, indices RD_FIFO_NUM..FN-1, where FN = RD_FIFO_NUM+WR_FIFO_NUM.
REQ-003 SHALL have parameter RD_FIFO_SIZE, default 4: depth of each read queue, at least 2.
REQ-004 SHALL have parameter WR_FIFO_SIZE, default 3: depth of each write queue, at least 2.
REQ-005 SHALL have parameters DQ=16, IDX=7, RA=16, CA=10: data, index, row and column widths.
REQ-006 SHALL define OW = $clog2(max(RD_FIFO_SIZE,WR_FIFO_SIZE)+1) as the occupancy field width.
REQ-007 clk  input  1  single clock; all state updates on the rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 push  input  FN  one-hot enqueue request, bit i targets queue i.
REQ-010 pop  input  FN  one-hot dequeue request, bit i targets queue i.
REQ-011 dq_i  input  DQ  write data; stored by write queues only.
REQ-012 idx_i  input  IDX  transaction index.
REQ-013 ra_i  input  RA  row address.
REQ-014 ca_i  input  CA  column address.
REQ-015 grant  output  1  push accepted this cycle; combinational.
REQ-016 full  output  FN  full[i]=1 when occupancy of queue i equals its depth.
REQ-017 mid  output  FN  mid[i]=1 when 2*occupancy of queue i >= its depth.
REQ-018 valid_o  output  FN  valid_o[i]=1 when queue i is non-empty.
REQ-019 occ  output  FN*OW  occupancy of queue i in bits [i*OW +: OW].
REQ-020 last_ra  output  FN*RA  ra of the last accepted push to queue i, in bits [i*RA +: RA].
REQ-021 out_valid  output  1  registered dequeue result valid.
REQ-022 dq_o  output  DQ  dequeued data; 0 for read queues.
REQ-023 idx_o  output  IDX  dequeued index.
REQ-024 ra_o  output  RA  dequeued row address.
REQ-025 ca_o  output  CA  dequeued column address.
REQ-026 type_o  output  1  1 = read queue, 0 = write queue.
REQ-027 err  output  3  sticky flags: [0] push to full queue, [1] pop of empty queue, [2] multi-hot push or pop.

Function
REQ-028 Each queue SHALL be a circular buffer with read pointer, write pointer and occupancy counter; pointers wrap from depth-1 to 0 for any depth, including non-power-of-2 depths.
REQ-029 A push SHALL be accepted only if push is one-hot and full[i]=0 at the start of the cycle; a pop in the same cycle does not make room.
REQ-030 On an accepted push, grant=1 that cycle; the entry, and last_ra[i], update on the next edge.
REQ-031 A pop SHALL be accepted only if pop is one-hot and valid_o[i]=1; the entry is not bypassed from a same-cycle push.
REQ-032 On an accepted pop, the next edge sets out_valid=1 and loads the head entry and the queue's type into dq_o/idx_o/ra_o/ca_o/type_o; the read pointer then advances.
REQ-033 On a cycle with no accepted pop, the next edge sets out_valid=0 and data outputs hold their values.
REQ-034 Simultaneous accepted push and pop to the same queue SHALL leave occupancy unchanged and preserve FIFO order.
REQ-035 A push or pop vector with more than one bit set SHALL be ignored entirely and set err[2].
REQ-036 A rejected push to a full queue SHALL set err[0] and leave the queue unchanged.
REQ-037 A pop of an empty queue SHALL set err[1], and out_valid=0 next cycle.
REQ-038 full, mid, valid_o and occ SHALL derive from registered occupancy only, not from the current cycle's push or pop.
REQ-039 An all-zero push or pop vector SHALL be a no-op and SHALL NOT set err.

Reset
REQ-040 When rst_n=0, immediately and without waiting for clk: all pointers, occ, last_ra, err, out_valid, dq_o, idx_o, ra_o, ca_o and type_o SHALL be 0; queues read as empty and full=mid=valid_o=0. Stored entry contents are don't-care.
REQ-041 Reset asserted mid-operation SHALL discard all queued entries; after deassertion the first accepted push lands in slot 0.

Verification (defaults)
REQ-042 push=7'b0000001, ra_i=16'h1234 -> grant=1; next cycle occ[2:0]=1, valid_o[0]=1, last_ra[15:0]=16'h1234; then pop=7'b0000001 -> next cycle out_valid=1, ra_o=16'h1234, type_o=1, dq_o=0.
REQ-043 Three pushes to queue 4 -> mid[4]=1 after the second, full[4]=1 after the third; a fourth push -> grant=0, err[0]=1, occ[14:12] stays 3.
REQ-044 push=7'b0000011 -> grant=0, every occ unchanged, err[2]=1; pop=7'b0000100 with queue 2 empty -> out_valid=0 next cycle, err[1]=1.
REQ-045 Queue 5 holding A (dq=16'hAAAA): push B and pop 5 in the same cycle -> occ stays 1, dq_o=16'hAAAA, type_o=0; pop next cycle -> dq_o=B.
REQ-046 Five push/pop rounds on queue 6 (depth 3) -> pointers wrap, outputs come out in push order; rst_n pulled low mid-stream -> all outputs 0 asynchronously.
